// File: rtl/imm_encoder.sv
// Finds the immediate-field encoding of a 32-bit constant. It supports either the
// plain 12-bit form or the 8-bit-value/4-bit-rotation form, searching one rotation per cycle.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        len_sel,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [11:0] imm
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [31:0] val_q, val_d;
  logic        len_q, len_d;
  logic [11:0] imm_q, imm_d;
  logic        valid_q, valid_d;
  logic [31:0] rot;

  // Rotate left by twice the rotation field; a zero shift keeps the right-shift term at 0.
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [5:0] s;
    s = {1'b0, r, 1'b0};
    return (v << s) | (v >> (6'd32 - s));
  endfunction

  assign rot = rol2(val_q, r_q);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    val_d   = val_q;
    len_d   = len_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          len_d   = len_sel;
          r_d     = 4'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (len_q) begin
          valid_d = (val_q[31:12] == 20'd0);
          imm_d   = (val_q[31:12] == 20'd0) ? val_q[11:0] : 12'h000;
          state_d = DONE;
        end else if (rot[31:8] == 24'd0) begin
          valid_d = 1'b1;
          imm_d   = {r_q, rot[7:0]};
          state_d = DONE;
        end else if (r_q == 4'd15) begin
          valid_d = 1'b0;
          imm_d   = 12'h000;
          state_d = DONE;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      imm_q   <= 12'h000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  // Operand copies are pure data and only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    len_q <= len_d;
  end

  assign busy  = (state_q == SEARCH);
  assign done  = (state_q == DONE);
  assign valid = valid_q;
  assign imm   = imm_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: reset state, encoding results, latency, busy length,
// start hold, operand stability and reset abort.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        len_sel;
  logic        busy, done, valid;
  logic [11:0] imm;

  int total = 0;
  int bad   = 0;

  imm_encoder dut (
    .clk(clk), .reset(reset), .start(start), .value(value), .len_sel(len_sel),
    .busy(busy), .done(done), .valid(valid), .imm(imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge (edge 0). start is accepted on the next edge (edge 1);
  // done must first be seen after edge exp_edge.
  task automatic run_op(input string tag, input logic [31:0] v, input logic ls,
                        input int exp_edge, input logic exp_vld, input logic [11:0] exp_imm,
                        input bit chk_imm, input bit hold, input bit scramble);
    int edge_n, busy_n;
    bit seen;
    value = v; len_sel = ls; start = 1'b1;
    edge_n = 0; busy_n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (scramble) begin value = ~v; len_sel = ~ls; end
      edge_n++;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    chk({tag, "_done_edge"}, seen ? edge_n : -1, exp_edge);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_vld});
    if (chk_imm) chk({tag, "_imm"}, {20'd0, imm}, {20'd0, exp_imm});
    chk({tag, "_busy_cycles"}, busy_n, exp_edge - 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_one_cycle"}, {30'd0, busy, done}, 32'd0);
    if (hold) begin
      busy_n = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (busy || done) busy_n++;
      end
      chk({tag, "_no_rerun"}, busy_n, 0);
      chk({tag, "_imm_held"}, {20'd0, imm}, {20'd0, exp_imm});
    end
  endtask

  initial begin
    int ev;
    reset = 1'b1; start = 1'b0; value = 32'd0; len_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_imm", {20'd0, imm}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("ab",      32'h000000AB, 1'b0,  2, 1'b1, 12'h0AB, 1, 0, 0);
    run_op("zero",    32'h00000000, 1'b0,  2, 1'b1, 12'h000, 1, 0, 0);
    run_op("ff_top",  32'hFF000000, 1'b0,  6, 1'b1, 12'h4FF, 1, 0, 0);
    run_op("r15",     32'h000003FC, 1'b0, 17, 1'b1, 12'hFFF, 1, 0, 0);
    run_op("nomatch", 32'h00000102, 1'b0, 17, 1'b0, 12'h000, 1, 0, 0);
    run_op("p12_big", 32'h00001000, 1'b1,  2, 1'b0, 12'h000, 0, 0, 0);
    run_op("p12_abc", 32'h00000ABC, 1'b1,  2, 1'b1, 12'hABC, 1, 1, 0);
    run_op("scram",   32'h00AB0000, 1'b0, 10, 1'b1, 12'h8AB, 1, 0, 1);

    // Abort a search while the rotation counter holds 7.
    value = 32'h00000102; len_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_imm", {20'd0, imm}, 32'd0);
    ev = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) ev++;
    end
    chk("abort_no_done", ev, 0);

    // First request immediately after reset is released.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("post_rst", 32'hFF000000, 1'b0, 6, 1'b1, 12'h4FF, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The module SHALL have the following ports, clock and reset first:
  clk  input  1  sole clock, all state on rising edge
  reset  input  1  synchronous, active-high reset
  start  input  1  request pulse; sampled only in IDLE
  value  input  32  constant to encode; captured when start is accepted
  len_sel  input  1  0 = rotated 8-bit form, 1 = plain 12-bit form; captured with value
  busy  output  1  high while a search is in progress
  done  output  1  one-cycle completion pulse
  valid  output  1  1 = value is encodable in the selected form
  imm  output  12  encoded immediate field
REQ-002 The block SHALL have no parameters.
REQ-003 The block SHALL use one clock, clk, and one reset, reset; reset is synchronous and active-high.

Function
REQ-004 The encoding SHALL be the inverse of the processor's immediate extension: len_sel=1 gives imm = value[11:0], valid when value[31:12]==0; len_sel=0 gives imm = {rot[3:0], imm8} such that value == ROR({24'b0,imm8}, 2*rot).
REQ-005 The FSM SHALL have states IDLE, SEARCH and DONE; the state after reset is IDLE.
REQ-006 IDLE: when start=1 at a rising edge, the block SHALL latch value and len_sel, clear the rotation counter r to 0 and go to SEARCH; when start=0 it SHALL stay in IDLE.
REQ-007 SEARCH, len_sel=1: the block SHALL do one test (value[31:12]==0) and go to DONE on the next edge.
REQ-008 SEARCH, len_sel=0: each cycle the block SHALL test the current r and check that ROL(latched value, 2*r)[31:8]==0; r is 4 bits.
REQ-009 On a match, the block SHALL load imm={r,ROL(value,2r)[7:0]} and valid=1, then go to DONE.
REQ-010 The smallest matching r SHALL win.
REQ-011 If r==15 and there is no match, the block SHALL load imm=0 and valid=0 and go to DONE; r SHALL NOT wrap to a 17th test.
REQ-012 If there is no match and r<15, the block SHALL increment r and stay in SEARCH.
REQ-013 DONE SHALL last exactly one cycle, with done=1, and then go to IDLE unconditionally.
REQ-014 busy SHALL be 1 exactly while in SEARCH.
REQ-015 Latency: if start is sampled at edge 0 and the match is at rotation r, done SHALL be high in the cycle after edge r+2.
  - len_sel=1 is treated as r=0.
  - The no-match case is treated as r=15.
REQ-016 imm and valid SHALL be registered, update only on entry to DONE, and hold until the next entry to DONE.
REQ-017 start SHALL be ignored in SEARCH and DONE; there is no queuing.
  - A new request is accepted earliest on the edge after DONE.
REQ-018 Changes on value or len_sel after acceptance SHALL NOT affect the result in progress.

Reset
REQ-019 When reset=1 at a rising edge, the block SHALL force state=IDLE, r=0, busy=0, done=0, valid=0 and imm=12'h000, overriding start.
REQ-020 A reset during SEARCH or DONE SHALL abort the operation without producing a done pulse.
  - The first request after reset is accepted on the first edge with reset=0 and start=1.

Verification
REQ-021 The bench SHALL cover the following scenarios:
  - len_sel=0, value=0x000000AB -> done after edge 2, valid=1, imm=0x0AB; value=0 -> imm=0x000, valid=1.
  - len_sel=0, value=0xFF000000 -> r=4, done after edge 6, valid=1, imm=0x4FF; busy high for exactly 5 cycles.
  - len_sel=0, value=0x000003FC -> last rotation matches, r=15, valid=1, imm=0xFFF, done after edge 17.
  - len_sel=0, value=0x00000102 -> no encoding, done after edge 17, valid=0, imm=0x000; len_sel=1, value=0x00001000 -> valid=0 after edge 2.
  - len_sel=1, value=0x00000ABC -> valid=1, imm=0xABC.
    - start is held high during SEARCH and DONE; no second result until start is resampled in IDLE.
    - value is changed mid-search; the result is unaffected.
  - reset is asserted during SEARCH at r=7 -> next cycle busy=0, done=0, valid=0, imm=0, and no done pulse follows.
    - A new start right after reset is released completes normally.
